// File: rtl/regfile_pkg.sv
// Shared parameters and the write-back queue entry type for the register file.
package regfile_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned NREG   = 4;
  localparam int unsigned QDEPTH = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fifo2.sv
// Two-entry synchronous FIFO for write-back entries; head is held in a flop.
module wbq_fifo2
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty,
  output logic [1:0] count
);

  wb_entry_t  head_q, head_d;
  wb_entry_t  tail_q, tail_d;
  logic [1:0] count_q, count_d;

  assign head  = head_q;
  assign count = count_q;
  assign full  = (count_q == 2'(QDEPTH));
  assign empty = (count_q == 2'd0);

  // Next-state: the caller never pushes when full nor pops when empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_entry;
        end else begin
          tail_d = push_entry;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop only happens at count 1 (push is blocked when full).
        if (count_q == 2'd1) begin
          head_d = push_entry;
        end else begin
          head_d = tail_q;
          tail_d = push_entry;
        end
      end
      default: ;
    endcase
  end

  // Queue state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/regfile4x64_wb.sv
// Four-entry 64-bit register file with a queued write-back port and busy scoreboard.
module regfile4x64_wb
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              hold,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  output logic [DATA_W-1:0] R0,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] R3,
  output logic [NREG-1:0]   busy,
  output logic [1:0]        qcount,
  output logic              wb_err
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;

  wb_entry_t q_head;
  wb_entry_t q_in;
  logic      q_full, q_empty;
  logic      push, commit, rsv_fire;

  assign wb_ready  = !q_full && !reset;
  assign rsv_ready = !busy_q[rsv_addr] && !reset;
  assign push      = wb_valid && wb_ready;
  assign commit    = !q_empty && !hold && !reset;
  assign rsv_fire  = rsv_valid && rsv_ready;
  assign q_in      = '{addr: wb_addr, data: wb_data};

  wbq_fifo2 u_wbq (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (q_in),
    .pop        (commit),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (qcount)
  );

  // Commit the queue head, then apply a reservation so reserve wins over clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (commit) begin
      regs_d[q_head.addr] = q_head.data;
      busy_d[q_head.addr] = 1'b0;
      if (!busy_q[q_head.addr]) begin
        err_d = 1'b1;
      end
    end
    if (rsv_fire) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign R0     = regs_q[0];
  assign R1     = regs_q[1];
  assign R2     = regs_q[2];
  assign R3     = regs_q[3];
  assign busy   = busy_q;
  assign wb_err = err_q;

endmodule

// File: tb/tb_regfile4x64_wb.sv
// Directed self-checking bench for regfile4x64_wb.
module tb_regfile4x64_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_addr;
  logic [63:0] wb_data;
  logic        hold;
  logic        rsv_valid;
  logic [1:0]  rsv_addr;
  logic        rsv_ready;
  logic [63:0] R0, R1, R2, R3;
  logic [3:0]  busy;
  logic [1:0]  qcount;
  logic        wb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile4x64_wb dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .hold      (hold),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .R0        (R0),
    .R1        (R1),
    .R2        (R2),
    .R3        (R3),
    .busy      (busy),
    .qcount    (qcount),
    .wb_err    (wb_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_addr = 2'd0; wb_data = '0;
    hold = 1'b0; rsv_valid = 1'b0; rsv_addr = 2'd0;
    step(); step();
    chk("rst_wb_ready", 64'(wb_ready), 64'd0);
    chk("rst_rsv_ready", 64'(rsv_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_R0", R0, 64'd0);
    chk("idle_R1", R1, 64'd0);
    chk("idle_R2", R2, 64'd0);
    chk("idle_R3", R3, 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_qcount", 64'(qcount), 64'd0);
    chk("idle_wb_ready", 64'(wb_ready), 64'd1);
    chk("idle_rsv_ready", 64'(rsv_ready), 64'd1);
    chk("idle_err", 64'(wb_err), 64'd0);

    // Reserve R2 then write it back: commit one edge after acceptance.
    rsv_valid = 1'b1; rsv_addr = 2'd2;
    step();
    rsv_valid = 1'b0;
    chk("rsv2_busy", 64'(busy), 64'h4);
    chk("rsv2_ready_low", 64'(rsv_ready), 64'd0);
    wb_valid = 1'b1; wb_addr = 2'd2; wb_data = 64'hDEAD_BEEF_0000_0001;
    step();
    wb_valid = 1'b0;
    chk("wr2_acc_qcount", 64'(qcount), 64'd1);
    chk("wr2_acc_R2", R2, 64'd0);
    chk("wr2_acc_busy", 64'(busy), 64'h4);
    step();
    chk("wr2_R2", R2, 64'hDEAD_BEEF_0000_0001);
    chk("wr2_busy", 64'(busy), 64'h0);
    chk("wr2_qcount", 64'(qcount), 64'd0);
    chk("wr2_err", 64'(wb_err), 64'd0);

    // Commit to busy R3 with a same-cycle reserve of R3: reserve dropped.
    rsv_valid = 1'b1; rsv_addr = 2'd3;
    step();
    rsv_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 2'd3; wb_data = 64'h33;
    step();
    wb_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 2'd3;
    #1;
    chk("same3_rsv_ready", 64'(rsv_ready), 64'd0);
    step();
    rsv_valid = 1'b0;
    chk("same3_busy", 64'(busy), 64'h0);
    chk("same3_R3", R3, 64'h33);
    chk("same3_err", 64'(wb_err), 64'd0);

    // Commit to busy R0 while reserving idle R3: R0 clears, R3 becomes busy.
    rsv_valid = 1'b1; rsv_addr = 2'd0;
    step();
    rsv_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 2'd0; wb_data = 64'h44;
    step();
    wb_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 2'd3;
    #1;
    chk("cross_rsv_ready", 64'(rsv_ready), 64'd1);
    step();
    rsv_valid = 1'b0;
    chk("cross_busy", 64'(busy), 64'h8);
    chk("cross_R0", R0, 64'h44);
    chk("cross_err", 64'(wb_err), 64'd0);

    // Write R0 while not busy: data lands and the sticky error sets.
    wb_valid = 1'b1; wb_addr = 2'd0; wb_data = 64'h5;
    step();
    wb_valid = 1'b0;
    step();
    chk("err_R0", R0, 64'h5);
    chk("err_set", 64'(wb_err), 64'd1);
    chk("err_busy", 64'(busy), 64'h8);
    step(); step();
    chk("err_sticky", 64'(wb_err), 64'd1);

    // Hold fills the queue; release drains in order.
    rsv_valid = 1'b1; rsv_addr = 2'd1;
    step();
    rsv_valid = 1'b0;
    chk("rsv1_busy", 64'(busy), 64'hA);
    hold = 1'b1;
    wb_valid = 1'b1; wb_addr = 2'd1; wb_data = 64'h11;
    step();
    wb_data = 64'h22;
    step();
    chk("hold_wb_ready", 64'(wb_ready), 64'd0);
    chk("hold_qcount2", 64'(qcount), 64'd2);
    wb_data = 64'h33;
    step();
    wb_valid = 1'b0;
    chk("hold_third_dropped", 64'(qcount), 64'd2);
    chk("hold_R1_unchanged", R1, 64'd0);
    hold = 1'b0;
    step();
    chk("rel_R1_first", R1, 64'h11);
    chk("rel_qcount1", 64'(qcount), 64'd1);
    chk("rel_busy1", 64'(busy), 64'h8);
    step();
    chk("rel_R1_second", R1, 64'h22);
    chk("rel_qcount0", 64'(qcount), 64'd0);
    step();
    chk("rel_R1_final", R1, 64'h22);
    chk("rel_err_sticky", 64'(wb_err), 64'd1);

    // Reset with a full queue and busy = 1010 discards everything.
    rsv_valid = 1'b1; rsv_addr = 2'd1;
    step();
    rsv_valid = 1'b0;
    hold = 1'b1;
    wb_valid = 1'b1; wb_addr = 2'd2; wb_data = 64'hAA;
    step();
    wb_addr = 2'd3; wb_data = 64'hBB;
    step();
    wb_valid = 1'b0;
    chk("pre_rst_qcount", 64'(qcount), 64'd2);
    chk("pre_rst_busy", 64'(busy), 64'hA);
    hold = 1'b0;
    reset = 1'b1;
    step();
    chk("mid_rst_wb_ready", 64'(wb_ready), 64'd0);
    chk("mid_rst_qcount", 64'(qcount), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_R0", R0, 64'd0);
    chk("mid_rst_R1", R1, 64'd0);
    chk("mid_rst_R2", R2, 64'd0);
    chk("mid_rst_R3", R3, 64'd0);
    chk("mid_rst_err", 64'(wb_err), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_wb_ready", 64'(wb_ready), 64'd1);
    step();
    chk("post_rst_R2", R2, 64'd0);
    chk("post_rst_R3", R3, 64'd0);
    chk("post_rst_qcount", 64'(qcount), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile4x64_wb.md
# regfile4x64_wb

Four-entry, 64-bit architectural register file with a buffered write-back port and a per-register busy scoreboard. It sits directly upstream of the 4:1 read-address mux and drives that mux's R0..R3 inputs from registered state. Write-back results enter through a 2-deep valid/ready queue and commit one per cycle. The issue stage reserves destinations in the scoreboard so it can detect pending writes.

## Interface
- DATA_W, 64, register width
- NREG, 4, number of registers (fixed; ADDR_W = 2)
- QDEPTH, 2, write-back queue depth
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  write-back request present
- wb_ready  out  1  queue can accept (= not full and not reset)
- wb_addr  in  2  destination register
- wb_data  in  64  write data
- hold  in  1  freeze commits from queue (debug step); enqueue still allowed
- rsv_valid  in  1  issue stage reserves a destination
- rsv_addr  in  2  register to reserve
- rsv_ready  out  1  busy[rsv_addr] == 0
- R0, R1, R2, R3  out  64 each  registered contents, to read-address mux
- busy  out  4  scoreboard bit per register
- qcount  out  2  queue occupancy 0..2
- wb_err  out  1  sticky: a commit hit a non-busy register

## Operation
- Enqueue: wb_valid && wb_ready at an edge pushes {wb_addr, wb_data} into the tail.
- Commit: if queue non-empty and hold == 0, the head is written into R[head.addr] at the edge and popped.
- Enqueue and commit in the same cycle: both occur; qcount unchanged. With a full queue and a commit, wb_ready stays 0 that cycle; it is not combinationally recomputed from the pop.
- Reserve: rsv_valid && rsv_ready sets busy[rsv_addr]. rsv_valid with rsv_ready == 0 is ignored.
- Commit clears busy[head.addr].
- Commit and reserve to the same address in one cycle: commit clears, reserve sets, and the final value is busy = 1. rsv_ready is evaluated on the pre-edge busy value, so this reserve is accepted only if busy was already 0.
- Commit to a register whose busy is 0: data is still written, busy stays 0, and wb_err sets and holds until reset.
- No write-to-read bypass. R outputs always show committed state only.

## Timing
- Reset, synchronous: R0..R3 = 0, busy = 0, queue empty, qcount = 0, wb_err = 0. While reset is high, wb_ready = 0 and rsv_ready = 0, and enqueues and reserves are dropped.
- Reset asserted mid-operation discards queued entries and clears busy at that edge. No partial commit occurs.
- Latency with an empty queue and hold = 0: request accepted at edge N, committed at edge N+1. R and busy reflect the commit after edge N+1.
- Throughput is 1 commit/cycle sustained. wb_ready never deasserts when hold = 0.
- With hold = 1: two requests fill the queue and wb_ready drops after the second acceptance edge. Releasing hold commits head then tail on consecutive edges, preserving order.
- Two queued writes to the same register commit in order; the last value wins.
- Outputs R0..R3, busy, qcount and wb_err are pure flops. wb_ready and rsv_ready are combinational from flops plus rsv_addr and reset.

## Structure
- Shared package regfile_pkg holds DATA_W, ADDR_W = 2, NREG = 4, QDEPTH = 2, and the wb entry struct {addr[1:0], data[63:0]}.
- Sub-module wbq_fifo2 is a 2-entry synchronous FIFO with push/pop, full, empty, count, and registered head. This module owns the register array and scoreboard.

## Test plan
- Reset then idle: all R = 0, busy = 0, wb_ready = 1 and rsv_ready = 1 after reset drops; qcount = 0.
- Reserve R2, then write R2 = 0xDEAD_BEEF_0000_0001 accepted at edge N: R2 updates and busy[2] clears after edge N+1, wb_err = 0.
- hold = 1 with writes R1 = 0x11 and R1 = 0x22: after 2 edges wb_ready = 0 and qcount = 2. A third request is not accepted. Release hold: R1 = 0x11 then 0x22 on consecutive edges, and qcount goes 2, 1, 0.
- Same-cycle commit to R3 (busy) and reserve of R3 with busy[3] = 1: rsv_ready = 0, the reserve is dropped, and busy[3] ends 0. Repeat with busy[3] = 0 beforehand via another register: busy[3] ends 1.
- Write R0 = 0x5 with busy[0] = 0: R0 = 5 and wb_err = 1, and wb_err stays 1 until reset.
- Reset asserted with qcount = 2 and busy = 4'b1010: after the edge, queue is empty, busy = 0, and R values are 0. No queued data is committed.
